snes_dejitter_ctrl: RTL and testbench

- Lock and scheduling controller for the NTSC de-jitter path: measures CSYNC line period on the 21.477 MHz master clock and classifies each line as nominal (1364 cycles) or short (1360 cycles).
- Runs a lock state machine and, only when locked, schedules the 4-cycle GCLK stall and CSYNC hold that re-align short lines.
- Also measures lines per frame for NTSC/PAL reporting.
- Sits between the CSYNC input and the clock-gate/output mux; GCLK_EN_o is retimed to the falling edge by the downstream gate.

---
 rtl/snes_dejitter_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_snes_dejitter_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/snes_dejitter_ctrl.sv
// rtl/snes_dejitter_ctrl.sv - CSYNC line-period lock and GCLK stall scheduler for NTSC de-jitter
module snes_dejitter_ctrl #(
    parameter int HCNT_W        = 11,
    parameter int LINE_NOM      = 1364,
    parameter int LINE_SHORT    = 1360,
    parameter int HMIN          = 1024,
    parameter int STALL_CYC     = 4,
    parameter int LOCK_LINES    = 8,
    parameter int UNLOCK_LINES  = 3,
    parameter int VS_THRESH     = 256,
    parameter int PAL_MIN_LINES = 288
) (
    input  logic              MCLK_i,
    input  logic              RST_N_i,
    input  logic              CSYNC_i,
    input  logic              FORCE_BYPASS_i,
    output logic              GCLK_EN_o,
    output logic              CSYNC_o,
    output logic              LOCKED_o,
    output logic              ACTIVE_o,
    output logic [HCNT_W-1:0] LINE_LEN_o,
    output logic [9:0]        LINES_o,
    output logic              PAL_o
);
    localparam int GC_W = $clog2(LOCK_LINES + 1);
    localparam int BC_W = $clog2(UNLOCK_LINES + 1);
    localparam int GY_W = $clog2(STALL_CYC + 1);
    localparam int LC_W = $clog2(VS_THRESH + 1);

    localparam logic [HCNT_W-1:0] H_MAX     = '1;
    localparam logic [HCNT_W-1:0] H_MIN     = HCNT_W'(HMIN);
    localparam logic [HCNT_W-1:0] L_NOM     = HCNT_W'(LINE_NOM);
    localparam logic [HCNT_W-1:0] L_SHORT   = HCNT_W'(LINE_SHORT);
    localparam logic [GC_W-1:0]   GOOD_LAST = GC_W'(LOCK_LINES - 1);
    localparam logic [BC_W-1:0]   BAD_LAST  = BC_W'(UNLOCK_LINES - 1);
    localparam logic [GY_W-1:0]   STALL_LD  = GY_W'(STALL_CYC);
    localparam logic [LC_W-1:0]   VS_SAT    = LC_W'(VS_THRESH);
    localparam logic [9:0]        LCNT_MAX  = '1;
    localparam logic [9:0]        PAL_MIN   = 10'(PAL_MIN_LINES);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t            state, state_next;
    logic [GC_W-1:0]   good_cnt, good_cnt_next;
    logic [BC_W-1:0]   bad_cnt, bad_cnt_next;
    logic              csync_prev;
    logic [HCNT_W-1:0] h_cnt;
    logic [HCNT_W-1:0] line_len;
    logic              fe, acc, good_s, good_n, good, timeout;
    logic [GY_W-1:0]   g_cyc, g_cyc_next;
    logic              stall_load, hold;
    logic [LC_W-1:0]   low_cnt;
    logic              vs_seen, prev_vs, frame_start;
    logic [9:0]        line_cnt;

    assign fe          = csync_prev & ~CSYNC_i;
    assign acc         = fe & (h_cnt >= H_MIN);
    assign line_len    = h_cnt + HCNT_W'(1);
    assign good_s      = (line_len == L_SHORT);
    assign good_n      = (line_len == L_NOM);
    assign good        = good_s | good_n;
    assign timeout     = (h_cnt == H_MAX) & ~acc;
    assign LOCKED_o    = (state == LOCKED);
    assign ACTIVE_o    = LOCKED_o & ~FORCE_BYPASS_i;
    assign stall_load  = acc & good_s & ACTIVE_o & (g_cyc == '0);
    assign hold        = stall_load | (g_cyc > GY_W'(1));
    assign frame_start = acc & vs_seen & ~prev_vs;

    // Lock state and good/bad line run counters
    always_ff @(posedge MCLK_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            state    <= SEARCH;
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            state    <= state_next;
            good_cnt <= good_cnt_next;
            bad_cnt  <= bad_cnt_next;
        end
    end

    // Lock transitions, evaluated once per accepted edge or on h_cnt timeout
    always_comb begin
        state_next    = state;
        good_cnt_next = good_cnt;
        bad_cnt_next  = bad_cnt;
        if (timeout) begin
            state_next    = SEARCH;
            good_cnt_next = '0;
            bad_cnt_next  = '0;
        end else if (acc) begin
            case (state)
                SEARCH: begin
                    state_next    = MEASURE;
                    good_cnt_next = '0;
                    bad_cnt_next  = '0;
                end
                MEASURE: begin
                    if (!good) begin
                        good_cnt_next = '0;
                    end else if (good_cnt == GOOD_LAST) begin
                        state_next    = LOCKED;
                        good_cnt_next = '0;
                        bad_cnt_next  = '0;
                    end else begin
                        good_cnt_next = good_cnt + GC_W'(1);
                    end
                end
                LOCKED: begin
                    if (good) begin
                        bad_cnt_next = '0;
                    end else if (bad_cnt == BAD_LAST) begin
                        state_next    = SEARCH;
                        good_cnt_next = '0;
                        bad_cnt_next  = '0;
                    end else begin
                        bad_cnt_next = bad_cnt + BC_W'(1);
                    end
                end
                default: state_next = SEARCH;
            endcase
        end
    end

    // Stall countdown; a running stall is never reloaded
    always_comb begin
        g_cyc_next = g_cyc;
        if (stall_load) begin
            g_cyc_next = STALL_LD;
        end else if (g_cyc != '0) begin
            g_cyc_next = g_cyc - GY_W'(1);
        end
    end

    // Horizontal measurement, gate enable and held CSYNC output
    always_ff @(posedge MCLK_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            csync_prev <= 1'b1;
            h_cnt      <= '0;
            LINE_LEN_o <= '0;
            g_cyc      <= '0;
            GCLK_EN_o  <= 1'b1;
            CSYNC_o    <= 1'b1;
        end else begin
            csync_prev <= CSYNC_i;
            if (acc) begin
                h_cnt      <= '0;
                LINE_LEN_o <= line_len;
            end else if (h_cnt != H_MAX) begin
                h_cnt <= h_cnt + HCNT_W'(1);
            end
            g_cyc     <= g_cyc_next;
            GCLK_EN_o <= (g_cyc_next == '0);
            CSYNC_o   <= hold | CSYNC_i;
        end
    end

    // Vertical measurement: vs-line detection and lines-per-frame capture
    always_ff @(posedge MCLK_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            low_cnt  <= '0;
            vs_seen  <= 1'b0;
            prev_vs  <= 1'b0;
            line_cnt <= '0;
            LINES_o  <= '0;
            PAL_o    <= 1'b0;
        end else begin
            if (CSYNC_i) begin
                low_cnt <= '0;
            end else if (low_cnt != VS_SAT) begin
                low_cnt <= low_cnt + LC_W'(1);
            end
            if (acc) begin
                vs_seen <= 1'b0;
                prev_vs <= vs_seen;
                if (frame_start) begin
                    LINES_o  <= line_cnt;
                    PAL_o    <= (line_cnt >= PAL_MIN);
                    line_cnt <= 10'd1;
                end else if (line_cnt != LCNT_MAX) begin
                    line_cnt <= line_cnt + 10'd1;
                end
            end else if (low_cnt == VS_SAT) begin
                vs_seen <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_snes_dejitter_ctrl.sv
// tb/tb_snes_dejitter_ctrl.sv - directed bench for snes_dejitter_ctrl
module tb_snes_dejitter_ctrl;
    logic        mclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csync = 1'b1;
    logic        bypass = 1'b0;
    logic        gclk_en, csync_out, locked, active, pal;
    logic [10:0] line_len;
    logic [9:0]  lines;

    logic        v_rst_n = 1'b0;
    logic        v_csync = 1'b1;
    logic        v_gclk_en, v_csync_out, v_locked, v_active, v_pal;
    logic [4:0]  v_line_len;
    logic [9:0]  v_lines;

    int vectors = 0;
    int miscompares = 0;
    int fall_dly, en_low, en_first;

    always #5 mclk = ~mclk;

    snes_dejitter_ctrl dut (
        .MCLK_i(mclk), .RST_N_i(rst_n), .CSYNC_i(csync), .FORCE_BYPASS_i(bypass),
        .GCLK_EN_o(gclk_en), .CSYNC_o(csync_out), .LOCKED_o(locked), .ACTIVE_o(active),
        .LINE_LEN_o(line_len), .LINES_o(lines), .PAL_o(pal)
    );

    snes_dejitter_ctrl #(
        .HCNT_W(5), .LINE_NOM(12), .LINE_SHORT(10), .HMIN(8), .VS_THRESH(4)
    ) vdut (
        .MCLK_i(mclk), .RST_N_i(v_rst_n), .CSYNC_i(v_csync), .FORCE_BYPASS_i(1'b0),
        .GCLK_EN_o(v_gclk_en), .CSYNC_o(v_csync_out), .LOCKED_o(v_locked), .ACTIVE_o(v_active),
        .LINE_LEN_o(v_line_len), .LINES_o(v_lines), .PAL_o(v_pal)
    );

    task automatic idle(input int n);
        csync = 1'b1;
        repeat (n) begin
            @(posedge mclk); #1;
        end
    endtask

    // One line starting with a falling edge; records output CSYNC fall delay and GCLK low cycles
    task automatic send_line(input int period, input int low, input int glitch_at);
        fall_dly = -1; en_low = 0; en_first = -1;
        for (int i = 0; i < period; i++) begin
            if (i < low) csync = 1'b0;
            else if (glitch_at > 0 && i >= glitch_at && i < glitch_at + 10) csync = 1'b0;
            else csync = 1'b1;
            @(negedge mclk);
            if (csync_out === 1'b0 && fall_dly < 0) fall_dly = i;
            if (gclk_en === 1'b0) begin
                en_low++;
                if (en_first < 0) en_first = i;
            end
            @(posedge mclk); #1;
        end
    endtask

    task automatic send_vline(input int period, input int low);
        for (int i = 0; i < period; i++) begin
            v_csync = (i < low) ? 1'b0 : 1'b1;
            @(posedge mclk); #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; v_rst_n = 1'b0; csync = 1'b1; bypass = 1'b0;
        repeat (3) @(posedge mclk);
        #1;
        vectors++; if (gclk_en !== 1'b1) begin miscompares++; $display("FAIL reset_gclk_en: got %b expected 1", gclk_en); end
        vectors++; if (csync_out !== 1'b1) begin miscompares++; $display("FAIL reset_csync: got %b expected 1", csync_out); end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %b expected 0", locked); end
        vectors++; if (active !== 1'b0) begin miscompares++; $display("FAIL reset_active: got %b expected 0", active); end
        vectors++; if (line_len !== 11'd0) begin miscompares++; $display("FAIL reset_line_len: got %0d expected 0", line_len); end
        vectors++; if (lines !== 10'd0) begin miscompares++; $display("FAIL reset_lines: got %0d expected 0", lines); end
        vectors++; if (pal !== 1'b0) begin miscompares++; $display("FAIL reset_pal: got %b expected 0", pal); end
        vectors++; if (v_lines !== 10'd0) begin miscompares++; $display("FAIL reset_v_lines: got %0d expected 0", v_lines); end
        rst_n = 1'b1; v_rst_n = 1'b1;
        @(posedge mclk); #1;
    endtask

    task automatic test_lock;
        idle(1030);
        for (int k = 0; k < 8; k++) send_line(1364, 100, 0);
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL lock_after_8_edges: got %b expected 0", locked); end
        send_line(1364, 100, 0);
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL lock_at_9th_edge: got %b expected 1", locked); end
        vectors++; if (active !== 1'b1) begin miscompares++; $display("FAIL lock_active: got %b expected 1", active); end
        vectors++; if (line_len !== 11'd1364) begin miscompares++; $display("FAIL lock_line_len: got %0d expected 1364", line_len); end
        send_line(1364, 100, 0);
        vectors++; if (en_low !== 0) begin miscompares++; $display("FAIL nominal_no_stall: got %0d low cycles expected 0", en_low); end
        vectors++; if (fall_dly !== 1) begin miscompares++; $display("FAIL nominal_csync_delay: got %0d expected 1", fall_dly); end
    endtask

    task automatic test_short_stall;
        send_line(1360, 100, 0);
        vectors++; if (en_low !== 0) begin miscompares++; $display("FAIL pre_short_no_stall: got %0d expected 0", en_low); end
        send_line(1364, 100, 0);
        vectors++; if (en_low !== 4) begin miscompares++; $display("FAIL short_stall_len: got %0d expected 4", en_low); end
        vectors++; if (en_first !== 1) begin miscompares++; $display("FAIL short_stall_start: got %0d expected 1", en_first); end
        vectors++; if (fall_dly !== 5) begin miscompares++; $display("FAIL short_csync_delay: got %0d expected 5", fall_dly); end
        vectors++; if (line_len !== 11'd1360) begin miscompares++; $display("FAIL short_line_len: got %0d expected 1360", line_len); end
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL short_keeps_lock: got %b expected 1", locked); end
    endtask

    task automatic test_bypass;
        bypass = 1'b1;
        #1;
        vectors++; if (active !== 1'b0) begin miscompares++; $display("FAIL bypass_active: got %b expected 0", active); end
        send_line(1360, 100, 0);
        send_line(1364, 100, 0);
        vectors++; if (en_low !== 0) begin miscompares++; $display("FAIL bypass_no_stall: got %0d expected 0", en_low); end
        vectors++; if (fall_dly !== 1) begin miscompares++; $display("FAIL bypass_csync_delay: got %0d expected 1", fall_dly); end
        vectors++; if (line_len !== 11'd1360) begin miscompares++; $display("FAIL bypass_line_len: got %0d expected 1360", line_len); end
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL bypass_locked: got %b expected 1", locked); end
        bypass = 1'b0;
    endtask

    task automatic test_glitch;
        send_line(1364, 100, 500);
        vectors++; if (line_len !== 11'd1364) begin miscompares++; $display("FAIL glitch_ignored: got %0d expected 1364", line_len); end
        send_line(1364, 100, 0);
        vectors++; if (line_len !== 11'd1364) begin miscompares++; $display("FAIL glitch_line_len: got %0d expected 1364", line_len); end
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL glitch_locked: got %b expected 1", locked); end
    endtask

    task automatic test_bad_tolerance;
        send_line(1200, 100, 0);
        send_line(1200, 100, 0);
        send_line(1364, 100, 0);
        send_line(1364, 100, 0);
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL two_bad_one_good: got %b expected 1", locked); end
        send_line(1200, 100, 0);
        send_line(1200, 100, 0);
        send_line(1364, 100, 0);
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL bad_cnt_cleared: got %b expected 1", locked); end
    endtask

    task automatic test_unlock;
        for (int k = 0; k < 3; k++) send_line(1200, 100, 0);
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL unlock_after_2_bad: got %b expected 1", locked); end
        send_line(1364, 100, 0);
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL unlock_after_3_bad: got %b expected 0", locked); end
        vectors++; if (line_len !== 11'd1200) begin miscompares++; $display("FAIL unlock_line_len: got %0d expected 1200", line_len); end
        for (int k = 0; k < 8; k++) send_line(1364, 100, 0);
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL relock_early: got %b expected 0", locked); end
        send_line(1364, 100, 0);
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL relock: got %b expected 1", locked); end
    endtask

    task automatic test_reset_mid_stall;
        send_line(1360, 100, 0);
        csync = 1'b0;
        @(posedge mclk); #1;
        @(posedge mclk); #1;
        vectors++; if (gclk_en !== 1'b0) begin miscompares++; $display("FAIL stall_in_progress: got %b expected 0", gclk_en); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (gclk_en !== 1'b1) begin miscompares++; $display("FAIL async_reset_gclk: got %b expected 1", gclk_en); end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL async_reset_locked: got %b expected 0", locked); end
        vectors++; if (csync_out !== 1'b1) begin miscompares++; $display("FAIL async_reset_csync: got %b expected 1", csync_out); end
        vectors++; if (line_len !== 11'd0) begin miscompares++; $display("FAIL async_reset_line_len: got %0d expected 0", line_len); end
        csync = 1'b1;
        repeat (3) @(posedge mclk);
        #1 rst_n = 1'b1;
        idle(1030);
        for (int k = 0; k < 8; k++) send_line(1364, 100, 0);
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL post_reset_lock_early: got %b expected 0", locked); end
        send_line(1364, 100, 0);
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL post_reset_relock: got %b expected 1", locked); end
    endtask

    task automatic test_timeout;
        idle(2100);
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL timeout_search: got %b expected 0", locked); end
        vectors++; if (gclk_en !== 1'b1) begin miscompares++; $display("FAIL timeout_gclk_en: got %b expected 1", gclk_en); end
    endtask

    task automatic test_frames;
        repeat (5) begin
            @(posedge mclk); #1;
        end
        for (int k = 0; k < 3; k++) send_vline(12, 6);
        for (int k = 0; k < 259; k++) send_vline(12, 1);
        for (int k = 0; k < 3; k++) send_vline(12, 6);
        for (int k = 0; k < 309; k++) send_vline(12, 1);
        vectors++; if (v_lines !== 10'd262) begin miscompares++; $display("FAIL ntsc_lines: got %0d expected 262", v_lines); end
        vectors++; if (v_pal !== 1'b0) begin miscompares++; $display("FAIL ntsc_pal: got %b expected 0", v_pal); end
        send_vline(12, 6);
        send_vline(12, 1);
        vectors++; if (v_lines !== 10'd312) begin miscompares++; $display("FAIL pal_lines: got %0d expected 312", v_lines); end
        vectors++; if (v_pal !== 1'b1) begin miscompares++; $display("FAIL pal_flag: got %b expected 1", v_pal); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_short_stall();
        test_bypass();
        test_glitch();
        test_bad_tolerance();
        test_unlock();
        test_reset_mid_stall();
        test_timeout();
        test_frames();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end
endmodule
